// File: rtl/pll_lock_mon_pkg.sv
// ---------------------------------------------------------------------------
// pll_lock_mon_pkg
// Shared definitions for the PLL lock monitor / reset controller.
//   STATE_W, CNT_W, LOSS_CNT_W : widths of the state, dwell counter and
//                                lock-loss counter
//   state_t                    : controller states with fixed debug encodings
//   cnt_inc                    : saturating dwell-counter increment
// ---------------------------------------------------------------------------
package pll_lock_mon_pkg;

  localparam int STATE_W    = 3;
  localparam int CNT_W      = 16;
  localparam int LOSS_CNT_W = 8;

  // The encodings are visible on STATE_OUT, so they are pinned explicitly.
  // Values 6 and 7 are unused and recover to WAIT_EN.
  typedef enum logic [STATE_W-1:0] {
    WAIT_EN   = 3'd0,
    WAIT_LOCK = 3'd1,
    QUAL      = 3'd2,
    RUN       = 3'd3,
    HOLD      = 3'd4,
    RESTART   = 3'd5
  } state_t;

  // The dwell counter must never wrap. If it wrapped, a long stay in a state
  // could appear to match a terminal count a second time.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// ---------------------------------------------------------------------------
// pll_lock_sync
// Multi-flop synchronizer that brings the asynchronous PLL lock flag into the
// reference clock domain.
//   clk : destination clock
//   rst : asynchronous, active-high reset (chain clears to 0)
//   d   : asynchronous input
//   q   : synchronized output, STAGES clock edges behind d
// ---------------------------------------------------------------------------
module pll_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;

  // Shift the raw lock flag through the synchronizer chain. The first flop
  // may go metastable. The later stages give it time to resolve before any
  // logic looks at the value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_monitor_reset_ctrl.sv
// ---------------------------------------------------------------------------
// pll_lock_monitor_reset_ctrl
// Output-side companion to the PLL bring-up sequencer. It qualifies PLL lock,
// releases the fabric reset once the clocks are usable, and watches for lock
// loss. On lock loss, or when lock never arrives, it pulses RESTART_REQ so the
// sequencer reruns bring-up.
//   FREF            : reference clock, all logic on the rising edge
//   RESET           : asynchronous, active-high reset
//   POWERDOWN_N     : sequencer power-up indication (sampled directly)
//   OUTx_EN         : sequencer output-enable indication (sampled directly)
//   PLL_LOCK        : asynchronous PLL lock flag
//   FABRIC_RESET_N  : downstream reset, low while clocks are not usable
//   READY           : clocks qualified and usable
//   RESTART_REQ     : request to restart the sequencer
//   LOCK_LOSS_COUNT : saturating count of lock-loss events seen in RUN
//   STATE_OUT       : current controller state (debug)
// ---------------------------------------------------------------------------
module pll_lock_monitor_reset_ctrl
  import pll_lock_mon_pkg::*;
#(
  parameter int               SYNC_STAGES          = 2,
  parameter logic [CNT_W-1:0] LOCK_QUAL_CYCLES     = 16'd200,
  parameter logic [CNT_W-1:0] LOCK_TIMEOUT_CYCLES  = 16'd4000,
  parameter logic [CNT_W-1:0] RESET_HOLD_CYCLES    = 16'd16,
  parameter logic [CNT_W-1:0] RESTART_PULSE_CYCLES = 16'd4
) (
  input  logic                  FREF,
  input  logic                  RESET,
  input  logic                  POWERDOWN_N,
  input  logic                  OUTx_EN,
  input  logic                  PLL_LOCK,
  output logic                  FABRIC_RESET_N,
  output logic                  READY,
  output logic                  RESTART_REQ,
  output logic [LOSS_CNT_W-1:0] LOCK_LOSS_COUNT,
  output logic [STATE_W-1:0]    STATE_OUT
);

  // Terminal counts. A state is left when the dwell counter holds the
  // "last" value, so the state lasts exactly the configured number of cycles.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = LOCK_TIMEOUT_CYCLES - CNT_W'(1);
  localparam logic [CNT_W-1:0] QUAL_LAST    = LOCK_QUAL_CYCLES - CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = RESET_HOLD_CYCLES - CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = RESTART_PULSE_CYCLES - CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             lock_s;
  logic             en;
  logic             loss_event;
  logic             run_next;
  logic             restart_next;

  pll_lock_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(FREF),
    .rst(RESET),
    .d  (PLL_LOCK),
    .q  (lock_s)
  );

  // The sequencer drives both enables on the opposite FREF edge. Half a
  // cycle of settling is enough, so they are used without a synchronizer.
  assign en = POWERDOWN_N & OUTx_EN;

  // Next-state logic. A lock drop in RUN takes priority over an enable drop,
  // so a simultaneous drop is still recorded as a lock-loss event. A lock
  // glitch during qualification only restarts qualification. It is not a
  // lock-loss event. The dwell counter restarts from zero on every state
  // change, and it stays at zero while waiting for enable.
  always_comb begin
    state_next = state;
    loss_event = 1'b0;
    case (state)
      WAIT_EN: begin
        if (en) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (!en)                      state_next = WAIT_EN;
        else if (lock_s)              state_next = QUAL;
        else if (cnt == TIMEOUT_LAST) state_next = RESTART;
      end
      QUAL: begin
        if (!en)                   state_next = WAIT_EN;
        else if (!lock_s)          state_next = WAIT_LOCK;
        else if (cnt == QUAL_LAST) state_next = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          state_next = HOLD;
          loss_event = 1'b1;
        end else if (!en) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) state_next = RESTART;
      end
      RESTART: begin
        if (cnt == PULSE_LAST) state_next = WAIT_EN;
      end
      default: state_next = WAIT_EN;
    endcase

    if ((state_next != state) || (state == WAIT_EN)) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_inc(cnt);
    end
  end

  // Output decode from the next state. The outputs are registered together
  // with the state, so they change on the same clock edge as the state does.
  always_comb begin
    run_next     = (state_next == RUN);
    restart_next = (state_next == RESTART);
  end

  // State, dwell counter, registered outputs and lock-loss counter. The
  // lock-loss counter saturates rather than wrapping. Only RESET clears it,
  // so it keeps its history across restarts.
  always_ff @(posedge FREF or posedge RESET) begin
    if (RESET) begin
      state           <= WAIT_EN;
      cnt             <= '0;
      FABRIC_RESET_N  <= 1'b0;
      READY           <= 1'b0;
      RESTART_REQ     <= 1'b0;
      LOCK_LOSS_COUNT <= '0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      FABRIC_RESET_N <= run_next;
      READY          <= run_next;
      RESTART_REQ    <= restart_next;
      if (loss_event && (LOCK_LOSS_COUNT != {LOSS_CNT_W{1'b1}})) begin
        LOCK_LOSS_COUNT <= LOCK_LOSS_COUNT + LOSS_CNT_W'(1);
      end
    end
  end

  assign STATE_OUT = state;

endmodule

// File: tb/tb_pll_lock_monitor_reset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_monitor_reset_ctrl
// Self-checking bench for pll_lock_monitor_reset_ctrl. A behavioural model
// tracks the phase, the time spent in it, the delayed lock view and the loss
// tally. Every output is compared after every clock edge.
// ---------------------------------------------------------------------------
module tb_pll_lock_monitor_reset_ctrl;

  localparam int SYNC    = 2;
  localparam int QUAL    = 4;
  localparam int TIMEOUT = 20;
  localparam int HOLDC   = 3;
  localparam int PULSE   = 2;

  // Phase codes as they appear on STATE_OUT
  localparam int P_WAIT_EN   = 0;
  localparam int P_WAIT_LOCK = 1;
  localparam int P_QUAL      = 2;
  localparam int P_RUN       = 3;
  localparam int P_HOLD      = 4;
  localparam int P_RESTART   = 5;

  logic       fref = 1'b0;
  logic       reset = 1'b1;
  logic       powerdownN = 1'b0;
  logic       outxEn = 1'b0;
  logic       pllLock = 1'b0;
  logic       fabricResetN;
  logic       ready;
  logic       restartReq;
  logic [7:0] lockLossCount;
  logic [2:0] stateOut;

  int checkCount = 0;
  int passCount  = 0;

  // Model state: current phase, cycles already spent in it, loss tally, and
  // the PLL_LOCK samples that are still in flight through the synchronizer
  int mPhase;
  int mSpent;
  int mLoss;
  bit lockHist[$];

  pll_lock_monitor_reset_ctrl #(
    .SYNC_STAGES         (SYNC),
    .LOCK_QUAL_CYCLES    (16'(QUAL)),
    .LOCK_TIMEOUT_CYCLES (16'(TIMEOUT)),
    .RESET_HOLD_CYCLES   (16'(HOLDC)),
    .RESTART_PULSE_CYCLES(16'(PULSE))
  ) dut (
    .FREF           (fref),
    .RESET          (reset),
    .POWERDOWN_N    (powerdownN),
    .OUTx_EN        (outxEn),
    .PLL_LOCK       (pllLock),
    .FABRIC_RESET_N (fabricResetN),
    .READY          (ready),
    .RESTART_REQ    (restartReq),
    .LOCK_LOSS_COUNT(lockLossCount),
    .STATE_OUT      (stateOut)
  );

  // Free-running reference clock
  always #5 fref = ~fref;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", tag, observed, expected, $time);
  endtask

  task automatic modelReset();
    mPhase = P_WAIT_EN;
    mSpent = 0;
    mLoss  = 0;
    lockHist.delete();
    for (int i = 0; i < SYNC; i++) lockHist.push_back(1'b0);
  endtask

  // One rising edge of the model. The controller sees the lock value that was
  // sampled SYNC edges earlier. A phase ends once it has lasted its
  // configured number of cycles.
  task automatic modelEdge(input bit en, input bit lockNow);
    bit lk;
    int nxt;
    lk = lockHist.pop_front();
    lockHist.push_back(lockNow);
    nxt = mPhase;
    mSpent++;
    case (mPhase)
      P_WAIT_EN:   if (en) nxt = P_WAIT_LOCK;
      P_WAIT_LOCK: nxt = !en ? P_WAIT_EN : lk ? P_QUAL : (mSpent == TIMEOUT) ? P_RESTART : mPhase;
      P_QUAL:      nxt = !en ? P_WAIT_EN : !lk ? P_WAIT_LOCK : (mSpent == QUAL) ? P_RUN : mPhase;
      P_RUN: begin
        if (!lk) begin
          nxt = P_HOLD;
          if (mLoss < 255) mLoss++;
        end else if (!en) begin
          nxt = P_HOLD;
        end
      end
      P_HOLD:      if (mSpent == HOLDC) nxt = P_RESTART;
      default:     if (mSpent == PULSE) nxt = P_WAIT_EN;
    endcase
    if (nxt != mPhase) mSpent = 0;
    mPhase = nxt;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_state"}, 16'(stateOut), 16'(mPhase));
    checkOutput({tag, "_ready"}, 16'(ready), 16'(mPhase == P_RUN));
    checkOutput({tag, "_fabric_rst_n"}, 16'(fabricResetN), 16'(mPhase == P_RUN));
    checkOutput({tag, "_restart_req"}, 16'(restartReq), 16'(mPhase == P_RESTART));
    checkOutput({tag, "_loss_count"}, 16'(lockLossCount), 16'(mLoss));
  endtask

  // Drive the inputs away from the clock edge, let one rising edge happen,
  // advance the model, and compare shortly after the edge
  task automatic applyStimulus(input bit pd, input bit oe, input bit lk);
    powerdownN = pd;
    outxEn     = oe;
    pllLock    = lk;
    @(posedge fref);
    modelEdge(pd & oe, lk);
    #1;
    checkAll("cyc");
  endtask

  // Assert reset in the middle of a cycle and check that the outputs clear
  // right away, without waiting for a clock edge
  task automatic doReset();
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkAll("async_rst");
    @(negedge fref);
    reset = 1'b0;
  endtask

  initial begin
    int readyEdge;
    int restartEdge;
    int restartCycles;
    int sawReady;
    int dropEdge;
    bit lockState;
    bit pd;
    bit oe;

    // Power-on reset
    doReset();

    // Normal bring-up. PLL_LOCK rises after edge 5, so READY comes up on edge 12
    readyEdge = 0;
    for (int e = 1; e <= 16; e++) begin
      applyStimulus(1'b1, 1'b1, e >= 6);
      if (ready && readyEdge == 0) readyEdge = e;
    end
    checkOutput("t1_ready_edge", 16'(readyEdge), 16'd12);

    // Lock timeout. RESTART_REQ rises on edge 21 and lasts 2 cycles
    doReset();
    restartEdge   = 0;
    restartCycles = 0;
    for (int e = 1; e <= 30; e++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (restartReq) begin
        restartCycles++;
        if (restartEdge == 0) restartEdge = e;
      end
    end
    checkOutput("t2_restart_edge", 16'(restartEdge), 16'd21);
    checkOutput("t2_restart_width", 16'(restartCycles), 16'd2);

    // A one-cycle lock glitch during qualification sends the controller back to WAIT_LOCK
    doReset();
    sawReady = 0;
    for (int e = 1; e <= 10; e++) begin
      applyStimulus(1'b1, 1'b1, e != 4);
      if (ready) sawReady = 1;
    end
    checkOutput("t3_ready_early", 16'(sawReady), 16'd0);
    checkOutput("t3_loss_count", 16'(lockLossCount), 16'd0);

    // Lock loss in RUN. READY drops on the third edge after the drop, then HOLD and RESTART follow
    for (int k = 0; k < 20 && mPhase != P_RUN; k++) applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t4_in_run", 16'(ready), 16'd1);
    dropEdge = 0;
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (!ready && dropEdge == 0) dropEdge = i;
    end
    checkOutput("t4_drop_latency", 16'(dropEdge), 16'd3);
    checkOutput("t4_loss_count", 16'(lockLossCount), 16'd1);

    // The loss counter saturates after many lock-loss events
    doReset();
    for (int n = 0; n < 260; n++) begin
      for (int k = 0; k < 40 && mPhase != P_RUN; k++) applyStimulus(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 40 && mPhase != P_WAIT_EN; k++) applyStimulus(1'b1, 1'b1, 1'b0);
    end
    checkOutput("t5_saturated", 16'(lockLossCount), 16'd255);

    // An enable drop in RUN moves to HOLD and does not count as a loss event
    for (int k = 0; k < 40 && mPhase != P_RUN; k++) applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t5_reach_run", 16'(stateOut), 16'(P_RUN));
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t5_endrop_state", 16'(stateOut), 16'(P_HOLD));
    checkOutput("t5_endrop_count", 16'(lockLossCount), 16'd255);

    // Reset asserted in HOLD, and again in RUN
    doReset();
    checkOutput("t6_hold_rst_count", 16'(lockLossCount), 16'd0);
    for (int k = 0; k < 40 && mPhase != P_RUN; k++) applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t6_reach_run", 16'(ready), 16'd1);
    doReset();
    checkOutput("t6_run_rst_state", 16'(stateOut), 16'd0);

    // Randomized traffic: mostly-high enables, a wandering lock flag, and an occasional reset
    lockState = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 6) lockState = ~lockState;
      pd = ($urandom_range(0, 99) < 98);
      oe = ($urandom_range(0, 99) < 98);
      applyStimulus(pd, oe, lockState);
      if ($urandom_range(0, 999) < 3) doReset();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
